wb_stage: RTL

- Writeback stage of the pipelined RV64 core; sits between the MEM/WB pipeline boundary and the `regfiles` block.
- Registers the retiring instruction and waits for load data from the LSU when needed.
- Sign/zero-extends load results, then drives the regfile write port and `pc_wb`, which triggers the difftest step.
- Also provides a WB→ID forwarding path and a retired-instruction counter.

---
 rtl/wb_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// RV64 writeback: registers the retiring instruction, waits for load data, extends it, and drives the regfile, difftest PC and forwarding.
// Latency: an ALU op commits one edge after accept, a load one edge after its response; mem_ready_o drops only while a load awaits data.
module wb_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wen_i,
  input  logic [XLEN-1:0]   mem_alu_res_i,
  input  logic              mem_is_load_i,
  input  logic [2:0]        mem_ld_funct3_i,
  input  logic [2:0]        mem_ld_off_i,
  input  logic              lsu_rdata_valid_i,
  input  logic [XLEN-1:0]   lsu_rdata_i,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [XLEN-1:0]   wr_data_o,
  output logic              wr_en_o,
  output logic [XLEN-1:0]   pc_wb_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_addr_o,
  output logic [XLEN-1:0]   fwd_data_o,
  output logic [63:0]       instret_o
);

  typedef enum logic [1:0] {IDLE, WAIT_LD, RETIRE} state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic [XLEN-1:0]   alu_res;
    logic              is_load;
    logic [2:0]        funct3;
    logic [2:0]        off;
  } wb_instr_t;

  state_t    state, state_next;
  wb_instr_t cur, incoming;
  logic [XLEN-1:0] ld_data, ld_ext, shifted;
  logic [5:0]      shamt;
  logic [63:0]     instret;
  logic            accept;

  assign mem_ready_o = (state != WAIT_LD);
  assign accept      = mem_valid_i && mem_ready_o;
  assign instret_o   = instret;

  always_comb begin
    incoming         = '0;
    incoming.pc      = mem_pc_i;
    incoming.rd      = mem_rd_addr_i;
    incoming.wen     = mem_rd_wen_i;
    incoming.alu_res = mem_alu_res_i;
    incoming.is_load = mem_is_load_i;
    incoming.funct3  = mem_ld_funct3_i;
    incoming.off     = mem_ld_off_i;
  end

  // Byte lane is forced to the natural alignment of the access size.
  always_comb begin
    shamt = 6'd0;
    case (cur.funct3[1:0])
      2'b00:   shamt = {cur.off, 3'b000};
      2'b01:   shamt = {cur.off[2:1], 1'b0, 3'b000};
      2'b10:   shamt = {cur.off[2], 2'b00, 3'b000};
      default: shamt = 6'd0;
    endcase
    shifted = lsu_rdata_i >> shamt;
    case (cur.funct3)
      3'b000:  ld_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b010:  ld_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b110:  ld_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ld_ext = lsu_rdata_i;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = mem_is_load_i ? WAIT_LD : RETIRE;
      WAIT_LD: if (lsu_rdata_valid_i) state_next = RETIRE;
      RETIRE:  state_next = accept ? (mem_is_load_i ? WAIT_LD : RETIRE) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      ld_data <= '0;
      instret <= 64'd0;
    end else begin
      state <= state_next;
      if (accept) cur <= incoming;
      if (state == WAIT_LD && lsu_rdata_valid_i) ld_data <= ld_ext;
      if (state == RETIRE) instret <= instret + 64'd1;
    end
  end

  always_comb begin
    wr_en_o     = 1'b0;
    wr_addr_o   = '0;
    wr_data_o   = '0;
    pc_wb_o     = '0;
    fwd_valid_o = 1'b0;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    if (state == RETIRE) begin
      wr_en_o     = cur.wen && (cur.rd != '0);
      wr_addr_o   = cur.rd;
      wr_data_o   = cur.is_load ? ld_data : cur.alu_res;
      pc_wb_o     = cur.pc;
      fwd_valid_o = wr_en_o;
      fwd_addr_o  = wr_addr_o;
      fwd_data_o  = wr_data_o;
    end
  end

endmodule
